wb_regfile: RTL
===============

Name: wb_regfile

Overview:
- Write-back stage plus architectural register file for the 5-stage RV32 pipeline.
- It is the responder to the decode stage's register interface:
  - serves the two read addresses that decode drives;
  - returns the read values;
  - produces the op_write / write_data / write_addr triple that decode forwards.
- It latches the MEM-stage results in a MEM/WB pipeline register, selects the write-back source, and commits it to a 32x32 array.
- It includes same-cycle write-to-read bypass.

Parameters:
- DATA_W, 32, data width of registers and write-back sources
- NREG, 32, number of architectural registers (x0..x31)
- IDX_W, 5, register index width (low bits of 32-bit address ports)
- SP_RESET, 32'd0, reset value of x2

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- mem_valid  in  1  MEM stage holds a real instruction (0 = bubble)
- mem_ctrl  in  3  WB control: [2]=op_write, [1:0]=source select
- mem_alu_result  in  32  ALU result from MEM
- mem_read_data  in  32  load data from data memory
- mem_pc4  in  32  PC+4 for jal/jalr link
- mem_rd  in  32  destination register (only [IDX_W-1:0] used)
- load_pc_reg_addr1  in  32  read address 1 from decode (only [4:0] used)
- load_pc_reg_addr2  in  32  read address 2 from decode
- load_pc_reg_value1  out  32  read data 1
- load_pc_reg_value2  out  32  read data 2
- op_write  out  1  write-back enable presented to decode
- write_data  out  32  write-back value
- write_addr  out  32  write-back register, zero-extended index
- retire_count  out  32  committed register writes since reset

Behaviour:
- Reset, asynchronous on negedge reset_n:
  - MEM/WB register cleared (valid=0, ctrl=0, data=0, rd=0).
  - All registers cleared to 0, except x2 = SP_RESET.
  - retire_count = 0.
  - op_write=0, write_data=0, write_addr=0.
  - Read outputs reflect the cleared array.
- MEM/WB register:
  - Captures mem_valid, mem_ctrl, the three data sources and mem_rd[4:0] on every posedge; no stall input.
  - Latency MEM→WB is 1 cycle.
- Source select, from the latched ctrl[1:0]:
  - 00 = ALU result
  - 01 = read data
  - 10 = pc4
  - 11 = reserved; behaves as ALU result
- Write-back outputs, combinational from the MEM/WB register:
  - op_write = valid & ctrl[2] & (rd != 0)
  - write_data = the selected source
  - write_addr = {27'b0, rd}
- Commit: at the posedge following the WB cycle, if op_write=1, then array[rd] <= write_data and retire_count increments.
  - retire_count wraps at 2^32 (modular).
- Reads: asynchronous. value_n = array[addr_n[4:0]].
  - addr_n[4:0]==0 → 0, always.
  - Bypass: if op_write=1 and addr_n[4:0]==write_addr[4:0], value_n = write_data (write-through). Decode in the same cycle therefore sees the value being committed.
  - Upper address bits [31:5] are ignored. Address 33 aliases x1.
- x0:
  - A write to x0 never changes the array, never asserts op_write and never counts.
  - A read of x0 returns 0 even if x0 is the bypass target.
- Bubbles: mem_valid=0 → op_write=0 in the WB cycle, array untouched, write_data still shows the mux output.
- Both read ports may target the same register; both bypass independently.
- Back-to-back writes to the same rd: the later one wins; the bypass always reflects the currently latched instruction.
- Reset asserted mid-operation: any pending commit is discarded; the array reverts to reset values immediately.

Decomposition:
- Shared package riscv_pkg holds:
  - WB select constants WB_SEL_ALU=2'b00, WB_SEL_MEM=2'b01, WB_SEL_PC4=2'b10;
  - the opcode localparams already used by decode;
  - the register index width.
- One sub-module, regfile_2r1w: the array, x0 hardwiring, reset and bypass.
- wb_regfile holds the MEM/WB register, the source mux and the counter.

Test Plan:
- Reset with SP_RESET=32'h0000_1000, then read addr1=2, addr2=0 → value1=0x1000, value2=0, op_write=0, retire_count=0.
- Drive mem_valid=1, ctrl=3'b100, alu=0x0000_00AB, rd=5 → next cycle op_write=1, write_addr=5, write_data=0xAB; reading addr1=5 in that cycle gives 0xAB via bypass; after the next edge it gives 0xAB from the array; retire_count=1.
- Load then jal:
  - ctrl=3'b101, read_data=0xDEAD_BEEF, rd=7 → x7=0xDEADBEEF.
  - ctrl=3'b110, pc4=0x0000_0044, rd=1 → x1=0x44.
  - ctrl=3'b111 with alu=0x55 → writes 0x55.
- Write 0x1234 to rd=0 and a bubble (mem_valid=0, ctrl=3'b100, rd=3) → op_write=0 both cycles, x0 reads 0, x3 unchanged, retire_count unchanged.
- Consecutive writes rd=9 of 0x11 then 0x22, with both read ports on addr 9 (and addr 41) → reads 0x11 then 0x22 in the respective WB cycles, final x9=0x22.
- Assert reset_n low between the WB cycle and the commit edge for rd=4 → x4 stays 0, op_write drops asynchronously to 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline constants: opcodes used by decode, write-back source
// selects and the architectural register index width.
package riscv_pkg;

  localparam int unsigned REG_IDX_W = 5;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/wb_regfile_if.sv
// Bus between the pipeline (MEM results, decode read ports) and the write-back
// stage / register file. The master drives MEM results and read addresses.
interface wb_regfile_if #(
  parameter int unsigned DATA_W = 32
);
  logic              mem_valid;
  logic [2:0]        mem_ctrl;
  logic [DATA_W-1:0] mem_alu_result;
  logic [DATA_W-1:0] mem_read_data;
  logic [DATA_W-1:0] mem_pc4;
  logic [31:0]       mem_rd;
  logic [31:0]       load_pc_reg_addr1;
  logic [31:0]       load_pc_reg_addr2;
  logic [DATA_W-1:0] load_pc_reg_value1;
  logic [DATA_W-1:0] load_pc_reg_value2;
  logic              op_write;
  logic [DATA_W-1:0] write_data;
  logic [31:0]       write_addr;
  logic [31:0]       retire_count;

  modport master (
    output mem_valid, mem_ctrl, mem_alu_result, mem_read_data, mem_pc4, mem_rd,
    output load_pc_reg_addr1, load_pc_reg_addr2,
    input  load_pc_reg_value1, load_pc_reg_value2, op_write, write_data, write_addr,
    input  retire_count
  );

  modport slave (
    input  mem_valid, mem_ctrl, mem_alu_result, mem_read_data, mem_pc4, mem_rd,
    input  load_pc_reg_addr1, load_pc_reg_addr2,
    output load_pc_reg_value1, load_pc_reg_value2, op_write, write_data, write_addr,
    output retire_count
  );
endinterface

// File: rtl/regfile_2r1w.sv
// Architectural register array: two asynchronous read ports with write-through
// bypass, one write port, x0 hardwired to zero.
module regfile_2r1w #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       NREG     = 32,
  parameter int unsigned       IDX_W    = 5,
  parameter logic [DATA_W-1:0] SP_RESET = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr1_i,
  input  logic [IDX_W-1:0]  raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (we_i && (waddr_i != '0)) begin
      regs_d[waddr_i] = wdata_i;
    end
  end

  // x2 is the stack pointer and comes out of reset pointing at SP_RESET.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= (i == 2) ? SP_RESET : '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    if (raddr1_i == '0) begin
      rdata1_o = '0;
    end else if (we_i && (raddr1_i == waddr_i)) begin
      rdata1_o = wdata_i;
    end
  end

  always_comb begin
    rdata2_o = regs_q[raddr2_i];
    if (raddr2_i == '0) begin
      rdata2_o = '0;
    end else if (we_i && (raddr2_i == waddr_i)) begin
      rdata2_o = wdata_i;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: MEM/WB pipeline register, write-back source mux, retire
// counter, and the architectural register file serving decode.
module wb_regfile
  import riscv_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       NREG     = 32,
  parameter int unsigned       IDX_W    = REG_IDX_W,
  parameter logic [DATA_W-1:0] SP_RESET = '0
) (
  input logic         clk,
  input logic         reset_n,
  wb_regfile_if.slave bus
);

  logic              valid_q, valid_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] rdat_q, rdat_d;
  logic [DATA_W-1:0] pc4_q, pc4_d;
  logic [IDX_W-1:0]  rd_q, rd_d;
  logic [31:0]       retire_q, retire_d;
  logic [DATA_W-1:0] wb_data;
  logic              wb_we;

  // No stall path: MEM/WB simply follows MEM every cycle.
  always_comb begin
    valid_d = bus.mem_valid;
    ctrl_d  = bus.mem_ctrl;
    alu_d   = bus.mem_alu_result;
    rdat_d  = bus.mem_read_data;
    pc4_d   = bus.mem_pc4;
    rd_d    = bus.mem_rd[IDX_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      ctrl_q   <= '0;
      alu_q    <= '0;
      rdat_q   <= '0;
      pc4_q    <= '0;
      rd_q     <= '0;
      retire_q <= '0;
    end else begin
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      alu_q    <= alu_d;
      rdat_q   <= rdat_d;
      pc4_q    <= pc4_d;
      rd_q     <= rd_d;
      retire_q <= retire_d;
    end
  end

  // Reserved select 2'b11 falls through to the ALU result.
  always_comb begin
    case (ctrl_q[1:0])
      WB_SEL_MEM: wb_data = rdat_q;
      WB_SEL_PC4: wb_data = pc4_q;
      default:    wb_data = alu_q;
    endcase
  end

  assign wb_we    = valid_q & ctrl_q[2] & (rd_q != '0);
  assign retire_d = retire_q + 32'(wb_we);

  assign bus.op_write     = wb_we;
  assign bus.write_data   = wb_data;
  assign bus.write_addr   = {{(32 - IDX_W){1'b0}}, rd_q};
  assign bus.retire_count = retire_q;

  regfile_2r1w #(
    .DATA_W   (DATA_W),
    .NREG     (NREG),
    .IDX_W    (IDX_W),
    .SP_RESET (SP_RESET)
  ) u_regfile (
    .clk      (clk),
    .reset_n  (reset_n),
    .we_i     (wb_we),
    .waddr_i  (rd_q),
    .wdata_i  (wb_data),
    .raddr1_i (bus.load_pc_reg_addr1[IDX_W-1:0]),
    .raddr2_i (bus.load_pc_reg_addr2[IDX_W-1:0]),
    .rdata1_o (bus.load_pc_reg_value1),
    .rdata2_o (bus.load_pc_reg_value2)
  );

  // Upper index bits alias onto the low registers.
  logic unused_upper;
  assign unused_upper = ^{bus.mem_rd[31:IDX_W], bus.load_pc_reg_addr1[31:IDX_W],
                          bus.load_pc_reg_addr2[31:IDX_W]};

endmodule
